pos_cmd_sequencer: RTL and testbench

Upstream feeder for the step/dir motor controller. Buffers absolute target positions from the host interface in a small FIFO, generates the ~4.096 ms control tick, and on each tick pops one target, computes the signed move relative to the last issued target, and presents it to the controller as a magnitude (`deltaPos`), a direction (`dir_req`) and a one-cycle `newPosSignal` strobe. One instance per motor axis.

---
 rtl/pos_cmd_sequencer.sv | 117 +++++++++++
 tb/tb_pos_cmd_sequencer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pos_cmd_sequencer.sv
// pos_cmd_sequencer: per-axis target FIFO, control tick and relative-move generator for the step/dir controller (define SOFT_LIMIT_EN to clamp targets to [POS_MIN, POS_MAX])
module pos_cmd_sequencer #(
  parameter int TICK_DIV = 40960,
  parameter int FIFO_DEPTH = 8,
  parameter logic [15:0] POS_MIN = 16'd0,
  parameter logic [15:0] POS_MAX = 16'd65535
) (
  input  logic        CLK_10MHZ,
  input  logic        RST_N,
  input  logic [15:0] pos_data,
  input  logic        pos_valid,
  output logic        pos_ready,
  input  logic        set_home,
  output logic        clock_4ms,
  output logic [15:0] deltaPos,
  output logic        dir_req,
  output logic        newPosSignal,
  output logic [15:0] cur_target,
  output logic [4:0]  fifo_level,
  output logic [7:0]  underrun_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TICK_DIV);
`ifdef SOFT_LIMIT_EN
  localparam bit LimitEn = 1'b1;
`else
  localparam bit LimitEn = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, POP, CALC, ISSUE} state_t;
  state_t state, nextState;
  logic [15:0] fifoMem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] tickCnt;
  logic [15:0] tgt, tgtLim, diff;
  logic push, popEn, calcEn, issueEn, underrunInc, tgtAbove;
  assign pos_ready = fifo_level != 5'(FIFO_DEPTH);
  assign push = pos_valid && pos_ready && !set_home;
  assign clock_4ms = tickCnt == CW'(TICK_DIV - 1);
  assign tgtLim = !LimitEn ? tgt : tgt < POS_MIN ? POS_MIN : tgt > POS_MAX ? POS_MAX : tgt;
  assign tgtAbove = tgtLim > cur_target;
  assign diff = tgtAbove ? tgtLim - cur_target : cur_target - tgtLim;
  // Free-running tick counter; wraps on the tick cycle
  always_ff @(posedge CLK_10MHZ or negedge RST_N)
    if (!RST_N) tickCnt <= '0;
    else tickCnt <= clock_4ms ? '0 : tickCnt + 1'b1;
  // FSM state register
  always_ff @(posedge CLK_10MHZ or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else state <= nextState;
  // Next state and per-state action enables; set_home forces IDLE and blocks every action
  always_comb begin
    nextState = state;
    popEn = 1'b0;
    calcEn = 1'b0;
    issueEn = 1'b0;
    underrunInc = 1'b0;
    if (set_home) nextState = IDLE;
    else
      case (state)
        IDLE: if (clock_4ms) begin
          nextState = fifo_level != 5'd0 ? POP : IDLE;
          underrunInc = fifo_level == 5'd0;
        end
        POP: begin
          popEn = 1'b1;
          nextState = CALC;
        end
        CALC: begin
          calcEn = 1'b1;
          nextState = ISSUE;
        end
        default: begin
          issueEn = 1'b1;
          nextState = IDLE;
        end
      endcase
  end
  // FIFO storage; no reset needed since occupancy is tracked separately
  always_ff @(posedge CLK_10MHZ)
    if (push) fifoMem[wrPtr] <= pos_data;
  // FIFO pointers and occupancy; set_home flushes
  always_ff @(posedge CLK_10MHZ or negedge RST_N)
    if (!RST_N) begin
      wrPtr <= '0;
      rdPtr <= '0;
      fifo_level <= '0;
    end else if (set_home) begin
      wrPtr <= '0;
      rdPtr <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (popEn) rdPtr <= rdPtr + 1'b1;
      fifo_level <= fifo_level + 5'(push) - 5'(popEn);
    end
  // Move datapath: latch head, compute move in CALC so the strobe lands in ISSUE, commit target at end of ISSUE
  always_ff @(posedge CLK_10MHZ or negedge RST_N)
    if (!RST_N) begin
      tgt <= '0;
      deltaPos <= '0;
      dir_req <= 1'b0;
      newPosSignal <= 1'b0;
      cur_target <= '0;
      underrun_cnt <= '0;
    end else begin
      newPosSignal <= calcEn && diff != 16'd0;
      if (popEn) tgt <= fifoMem[rdPtr];
      if (calcEn) tgt <= tgtLim;
      if (calcEn && diff != 16'd0) begin
        deltaPos <= diff;
        dir_req <= tgtAbove;
      end
      if (set_home) cur_target <= '0;
      else if (issueEn) cur_target <= tgt;
      if (underrunInc && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 1'b1;
    end
endmodule

// File: tb/tb_pos_cmd_sequencer.sv
// tb_pos_cmd_sequencer: directed bench for pos_cmd_sequencer with a shortened tick period
`timescale 1ns/1ps
module tb_pos_cmd_sequencer;
  localparam int TDIV = 32;
  logic CLK_10MHZ = 1'b0;
  logic RST_N = 1'b0;
  logic pos_valid = 1'b0;
  logic set_home = 1'b0;
  logic [15:0] pos_data = '0;
  logic pos_ready, clock_4ms, dir_req, newPosSignal;
  logic [15:0] deltaPos, cur_target;
  logic [4:0] fifo_level;
  logic [7:0] underrun_cnt;
  int checks = 0;
  int errors = 0;
  logic sawStrobe = 1'b0;
  logic [15:0] words [9] = '{16'd1100, 16'd500, 16'd3000, 16'd2999, 16'd65535, 16'd0, 16'd12345, 16'd12000, 16'd4242};
  logic [15:0] expDelta [8] = '{16'd700, 16'd600, 16'd2500, 16'd1, 16'd62536, 16'd65535, 16'd12345, 16'd345};
  logic expDir [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  always #50 CLK_10MHZ = ~CLK_10MHZ;

  pos_cmd_sequencer #(.TICK_DIV(TDIV), .FIFO_DEPTH(8), .POS_MIN(16'd0), .POS_MAX(16'd65535)) dut (
    .CLK_10MHZ(CLK_10MHZ), .RST_N(RST_N), .pos_data(pos_data), .pos_valid(pos_valid),
    .pos_ready(pos_ready), .set_home(set_home), .clock_4ms(clock_4ms), .deltaPos(deltaPos),
    .dir_req(dir_req), .newPosSignal(newPosSignal), .cur_target(cur_target),
    .fifo_level(fifo_level), .underrun_cnt(underrun_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK_10MHZ);
  endtask

  task automatic push(input logic [15:0] d);
    pos_data = d;
    pos_valid = 1'b1;
    cyc(1);
    pos_valid = 1'b0;
  endtask

  task automatic waitTick();
    int n = 0;
    do begin
      cyc(1);
      n++;
      sawStrobe |= newPosSignal;
    end while (!clock_4ms && n < 3 * TDIV);
    chk("tick_seen", clock_4ms, 1'b1);
  endtask

  task automatic issueCheck(input string tag, input logic strobe, input logic [15:0] d, input logic dr, input logic [15:0] tgt);
    waitTick();
    cyc(1);
    chk({tag, "_strobe_t1"}, newPosSignal, 1'b0);
    cyc(2);
    chk({tag, "_strobe_t3"}, newPosSignal, strobe);
    chk({tag, "_delta"}, deltaPos, d);
    chk({tag, "_dir"}, dir_req, dr);
    cyc(1);
    chk({tag, "_strobe_t4"}, newPosSignal, 1'b0);
    chk({tag, "_cur_target"}, cur_target, tgt);
  endtask

  initial begin
    cyc(2);
    chk("rst_cur_target", cur_target, 16'd0);
    chk("rst_delta", deltaPos, 16'd0);
    chk("rst_dir", dir_req, 1'b0);
    chk("rst_strobe", newPosSignal, 1'b0);
    chk("rst_tick", clock_4ms, 1'b0);
    chk("rst_level", fifo_level, 5'd0);
    chk("rst_underrun", underrun_cnt, 8'd0);
    chk("rst_ready", pos_ready, 1'b1);
    RST_N = 1'b1;
    cyc(1);
    push(16'd1000);
    chk("push_level", fifo_level, 5'd1);
    issueCheck("first", 1'b1, 16'd1000, 1'b1, 16'd1000);
    push(16'd400);
    issueCheck("back", 1'b1, 16'd600, 1'b0, 16'd400);
    push(16'd400);
    issueCheck("same", 1'b0, 16'd600, 1'b0, 16'd400);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("fill_ready%0d", i), pos_ready, i < 8);
      push(words[i]);
    end
    chk("full_level", fifo_level, 5'd8);
    chk("full_ready", pos_ready, 1'b0);
    for (int i = 0; i < 8; i++)
      issueCheck($sformatf("burst%0d", i), 1'b1, expDelta[i], expDir[i], words[i]);
    waitTick();
    cyc(3);
    chk("drop_strobe", newPosSignal, 1'b0);
    chk("drop_cur_target", cur_target, 16'd12000);
    chk("drop_level", fifo_level, 5'd0);
    sawStrobe = 1'b0;
    repeat (300) waitTick();
    cyc(4);
    chk("underrun_sat", underrun_cnt, 8'd255);
    chk("underrun_no_strobe", sawStrobe, 1'b0);
    push(16'd5000);
    push(16'd6000);
    waitTick();
    cyc(2);
    chk("home_level_before", fifo_level, 5'd1);
    set_home = 1'b1;
    pos_data = 16'd7777;
    pos_valid = 1'b1;
    cyc(1);
    set_home = 1'b0;
    pos_valid = 1'b0;
    chk("home_strobe_t3", newPosSignal, 1'b0);
    chk("home_cur_target", cur_target, 16'd0);
    chk("home_level", fifo_level, 5'd0);
    cyc(1);
    chk("home_strobe_t4", newPosSignal, 1'b0);
    chk("home_underrun", underrun_cnt, 8'd255);
    push(16'd300);
    issueCheck("after_home", 1'b1, 16'd300, 1'b1, 16'd300);
    chk("after_home_level", fifo_level, 5'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
